lb_window_sched: RTL and testbench

- Scheduler for the 64-bank depth line buffer. Sequences frame-1 row writes into banks and gates frame-0 read requests so each read hits a row that is fully written and still resident.
- Applies write backpressure so a row is never overwritten while a reader still needs it.
- Sits between the frame-1 depth stream / frame-0 warp pipeline and the line-buffer SRAM control datapath.

---
 rtl/RgbdVoConfigPk.sv | 25 ++
 rtl/lb_window_sched_if.sv | 49 ++++
 rtl/lb_row_window.sv | 73 +++++++
 rtl/lb_window_sched.sv | 209 ++++++++++++++++++++
 tb/tb_lb_window_sched.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/RgbdVoConfigPk.sv
// ---------------------------------------------------------------------------
// RgbdVoConfigPk
// Shared configuration for the depth line-buffer scheduler:
//   H_SIZE_BW / V_SIZE_BW  : widths of the row-width / frame-height fields
//   LB_NUM_BANKS           : line-buffer rows resident (power of 2)
//   LB_BANK_BW             : log2(LB_NUM_BANKS)
//   LB_FILL_ROWS           : complete rows required before the first read grant
//   lb_sched_state_e       : scheduler FSM state encoding (visible on o_state)
// ---------------------------------------------------------------------------
package RgbdVoConfigPk;

    localparam int H_SIZE_BW    = 12;
    localparam int V_SIZE_BW    = 11;
    localparam int LB_NUM_BANKS = 64;
    localparam int LB_BANK_BW   = 6;
    localparam int LB_FILL_ROWS = 8;

    typedef enum logic [1:0] {
        LB_IDLE  = 2'd0,
        LB_FILL  = 2'd1,
        LB_RUN   = 2'd2,
        LB_DRAIN = 2'd3
    } lb_sched_state_e;

endpackage

// File: rtl/lb_window_sched_if.sv
// ---------------------------------------------------------------------------
// lb_window_sched_if
// Write/read handshake bundle between the frame-1 depth stream / frame-0 warp
// pipeline (master) and the line-buffer scheduler (slave).
//   i_wr_valid / o_wr_ready       : frame-1 pixel handshake
//   o_wr_bank / o_wr_addr         : bank and column for the accepted pixel
//   i_rd_req / i_rd_row           : read request, held until granted
//   o_rd_gnt / o_rd_bank          : one-cycle grant and bank of granted row
//   i_rd_release                  : pulse, oldest needed row retired
// ---------------------------------------------------------------------------
interface lb_window_sched_if
    import RgbdVoConfigPk::*;
#(
    parameter int BANK_BW = LB_BANK_BW
);
    logic                 i_wr_valid;
    logic                 o_wr_ready;
    logic [BANK_BW-1:0]   o_wr_bank;
    logic [H_SIZE_BW-1:0] o_wr_addr;
    logic                 i_rd_req;
    logic [V_SIZE_BW-1:0] i_rd_row;
    logic                 o_rd_gnt;
    logic [BANK_BW-1:0]   o_rd_bank;
    logic                 i_rd_release;

    modport master (
        output i_wr_valid,
        input  o_wr_ready,
        input  o_wr_bank,
        input  o_wr_addr,
        output i_rd_req,
        output i_rd_row,
        input  o_rd_gnt,
        input  o_rd_bank,
        output i_rd_release
    );

    modport slave (
        input  i_wr_valid,
        output o_wr_ready,
        output o_wr_bank,
        output o_wr_addr,
        input  i_rd_req,
        input  i_rd_row,
        output o_rd_gnt,
        output o_rd_bank,
        input  i_rd_release
    );
endinterface

// File: rtl/lb_row_window.sv
// ---------------------------------------------------------------------------
// lb_row_window
// Tracks the resident row window of the line buffer: rows_done (rows fully
// written) and low_row (oldest row still needed by the reader), and evaluates
// the write-ready and read-grant window comparisons.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_clear          : clear both counters (frame start)
//   i_row_done       : a row completed this cycle
//   i_release        : oldest row retired (low_row++, saturating at i_vsize)
//   i_write_en       : scheduler is in a write-accepting state
//   i_grant_en       : scheduler is in a read-granting state
//   i_vsize          : frame height in rows
//   i_wr_y           : row currently being written
//   i_rd_row         : requested row
//   o_rows_done, o_low_row : counter values
//   o_wr_ready       : write side may accept a pixel
//   o_rd_ok          : requested row is written and still resident
// ---------------------------------------------------------------------------
module lb_row_window
    import RgbdVoConfigPk::*;
#(
    parameter int NUM_BANKS = LB_NUM_BANKS
)
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_row_done,
    input  logic                 i_release,
    input  logic                 i_write_en,
    input  logic                 i_grant_en,
    input  logic [V_SIZE_BW-1:0] i_vsize,
    input  logic [V_SIZE_BW-1:0] i_wr_y,
    input  logic [V_SIZE_BW-1:0] i_rd_row,
    output logic [V_SIZE_BW-1:0] o_rows_done,
    output logic [V_SIZE_BW-1:0] o_low_row,
    output logic                 o_wr_ready,
    output logic                 o_rd_ok
);
    localparam logic [V_SIZE_BW:0] WINDOW = (V_SIZE_BW+1)'(NUM_BANKS);

    logic [V_SIZE_BW-1:0] rows_done_reg;
    logic [V_SIZE_BW-1:0] low_row_reg;
    logic [V_SIZE_BW:0]   occupancy;

    // Row completion and release may land in the same cycle; both counters
    // update together and ready sees the new values next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rows_done_reg <= '0;
            low_row_reg   <= '0;
        end else if (i_clear) begin
            rows_done_reg <= '0;
            low_row_reg   <= '0;
        end else begin
            if (i_row_done)
                rows_done_reg <= rows_done_reg + V_SIZE_BW'(1);
            if (i_release && (low_row_reg < i_vsize))
                low_row_reg <= low_row_reg + V_SIZE_BW'(1);
        end
    end

    // Rows in flight between the reader's oldest needed row and the writer.
    // The writer never falls behind low_row, so this never wraps.
    assign occupancy   = {1'b0, i_wr_y} - {1'b0, low_row_reg};

    assign o_wr_ready  = i_write_en && (occupancy < WINDOW) && (i_wr_y < i_vsize);
    assign o_rd_ok     = i_grant_en && (rows_done_reg > i_rd_row) &&
                         (i_rd_row >= low_row_reg);
    assign o_rows_done = rows_done_reg;
    assign o_low_row   = low_row_reg;

endmodule

// File: rtl/lb_window_sched.sv
// ---------------------------------------------------------------------------
// lb_window_sched
// Scheduler for the 64-bank depth line buffer. Sequences frame-1 row writes
// into banks, gates frame-0 read requests to rows that are fully written and
// still resident, and backpressures writes so a row is never overwritten
// while the reader still needs it.
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_frame_start        : pulse, start of frame (aborts a frame in progress)
//   i_frame_end          : pulse, forces completion
//   r_hsize, r_vsize     : row width in pixels, frame height in rows
//   bus (slave)          : write/read handshakes, see lb_window_sched_if
//   o_state              : IDLE=0 FILL=1 RUN=2 DRAIN=3
//   o_frame_done         : one-cycle pulse on return to IDLE
//   o_abort              : one-cycle pulse, frame_start while not IDLE
// Optional build macro LB_SCHED_PERF_EN adds:
//   o_wr_stall_cnt       : cycles with a pixel offered but not accepted
//   o_rd_wait_cnt        : cycles with a read request held without grant
// ---------------------------------------------------------------------------
module lb_window_sched
    import RgbdVoConfigPk::*;
#(
    parameter int NUM_BANKS = LB_NUM_BANKS,
    parameter int BANK_BW   = LB_BANK_BW,
    parameter int FILL_ROWS = LB_FILL_ROWS
)
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_start,
    input  logic                 i_frame_end,
    input  logic [H_SIZE_BW-1:0] r_hsize,
    input  logic [V_SIZE_BW-1:0] r_vsize,
    lb_window_sched_if.slave     bus,
    output logic [1:0]           o_state,
    output logic                 o_frame_done,
`ifdef LB_SCHED_PERF_EN
    output logic [23:0]          o_wr_stall_cnt,
    output logic [23:0]          o_rd_wait_cnt,
`endif
    output logic                 o_abort
);
    localparam logic [V_SIZE_BW-1:0] FILL_ROWS_W = V_SIZE_BW'(FILL_ROWS);

    lb_sched_state_e      state_reg, state_next;
    logic [H_SIZE_BW-1:0] wr_x_reg;
    logic [V_SIZE_BW-1:0] wr_y_reg;
    logic                 gnt_reg, gnt_next;
    logic [BANK_BW-1:0]   rd_bank_reg;
    logic                 done_reg, done_next;
    logic                 abort_reg, abort_next;

    logic [V_SIZE_BW-1:0] rows_done;
    logic [V_SIZE_BW-1:0] low_row;
    logic [V_SIZE_BW-1:0] fill_target;
    logic                 wr_ready;
    logic                 rd_ok;
    logic                 accept;
    logic                 last_col;
    logic                 row_done;
    logic                 write_en;
    logic                 grant_en;

    assign write_en = (state_reg == LB_FILL) || (state_reg == LB_RUN);
    assign grant_en = (state_reg == LB_RUN)  || (state_reg == LB_DRAIN);

    lb_row_window #(
        .NUM_BANKS (NUM_BANKS)
    ) u_row_window (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (i_frame_start),
        .i_row_done  (row_done),
        .i_release   (bus.i_rd_release),
        .i_write_en  (write_en),
        .i_grant_en  (grant_en),
        .i_vsize     (r_vsize),
        .i_wr_y      (wr_y_reg),
        .i_rd_row    (bus.i_rd_row),
        .o_rows_done (rows_done),
        .o_low_row   (low_row),
        .o_wr_ready  (wr_ready),
        .o_rd_ok     (rd_ok)
    );

    // ---------------- write-side column/row counters ----------------
    assign accept   = bus.i_wr_valid && wr_ready;
    assign last_col = ({1'b0, wr_x_reg} + (H_SIZE_BW+1)'(1)) >= {1'b0, r_hsize};
    assign row_done = accept && last_col;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_x_reg <= '0;
            wr_y_reg <= '0;
        end else if (i_frame_start) begin
            wr_x_reg <= '0;
            wr_y_reg <= '0;
        end else if (accept) begin
            if (last_col) begin
                wr_x_reg <= '0;
                wr_y_reg <= wr_y_reg + V_SIZE_BW'(1);
            end else begin
                wr_x_reg <= wr_x_reg + H_SIZE_BW'(1);
            end
        end
    end

    // ---------------- FSM ----------------
    assign fill_target = (FILL_ROWS_W < r_vsize) ? FILL_ROWS_W : r_vsize;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= LB_IDLE;
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            abort_reg <= abort_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        abort_next = 1'b0;
        if (i_frame_start) begin
            // Restart from any state; only a restart mid-frame is an abort.
            state_next = LB_FILL;
            abort_next = (state_reg != LB_IDLE);
        end else begin
            case (state_reg)
                LB_IDLE: ;
                LB_FILL: begin
                    if (i_frame_end) begin
                        state_next = LB_IDLE;
                        done_next  = 1'b1;
                    end else if (rows_done >= fill_target) begin
                        state_next = LB_RUN;
                    end
                end
                LB_RUN: begin
                    if (i_frame_end) begin
                        state_next = LB_IDLE;
                        done_next  = 1'b1;
                    end else if (rows_done == r_vsize) begin
                        state_next = LB_DRAIN;
                    end
                end
                LB_DRAIN: begin
                    if ((low_row == r_vsize) || i_frame_end) begin
                        state_next = LB_IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = LB_IDLE;
            endcase
        end
    end

    // ---------------- read grant ----------------
    // gnt_reg blocks back-to-back grants, so a held request sees at most one
    // grant every two cycles. A frame restart drops anything pending.
    assign gnt_next = bus.i_rd_req && rd_ok && !gnt_reg && !i_frame_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_reg     <= 1'b0;
            rd_bank_reg <= '0;
        end else begin
            gnt_reg <= gnt_next;
            if (gnt_next)
                rd_bank_reg <= bus.i_rd_row[BANK_BW-1:0];
        end
    end

`ifdef LB_SCHED_PERF_EN
    logic [23:0] wr_stall_cnt_reg;
    logic [23:0] rd_wait_cnt_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_stall_cnt_reg <= '0;
            rd_wait_cnt_reg  <= '0;
        end else if (i_frame_start) begin
            wr_stall_cnt_reg <= '0;
            rd_wait_cnt_reg  <= '0;
        end else begin
            if (bus.i_wr_valid && !wr_ready && write_en && (wr_stall_cnt_reg != '1))
                wr_stall_cnt_reg <= wr_stall_cnt_reg + 24'd1;
            if (bus.i_rd_req && !gnt_reg && (rd_wait_cnt_reg != '1))
                rd_wait_cnt_reg <= rd_wait_cnt_reg + 24'd1;
        end
    end

    assign o_wr_stall_cnt = wr_stall_cnt_reg;
    assign o_rd_wait_cnt  = rd_wait_cnt_reg;
`endif

    // ---------------- outputs ----------------
    assign bus.o_wr_ready = wr_ready;
    assign bus.o_wr_bank  = wr_y_reg[BANK_BW-1:0];
    assign bus.o_wr_addr  = wr_x_reg;
    assign bus.o_rd_gnt   = gnt_reg;
    assign bus.o_rd_bank  = rd_bank_reg;
    assign o_state        = state_reg;
    assign o_frame_done   = done_reg;
    assign o_abort        = abort_reg;

endmodule

// File: tb/tb_lb_window_sched.sv
// ---------------------------------------------------------------------------
// tb_lb_window_sched
// Directed self-checking bench for lb_window_sched. Expected write
// (bank, addr) pairs and expected read-grant banks are queued as stimulus is
// driven and popped when the design accepts a pixel or issues a grant.
// ---------------------------------------------------------------------------
module tb_lb_window_sched;
    import RgbdVoConfigPk::*;

    typedef struct {
        int bank;
        int addr;
    } wr_exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 frame_start;
    logic                 frame_end;
    logic [H_SIZE_BW-1:0] hsize;
    logic [V_SIZE_BW-1:0] vsize;
    logic [1:0]           state;
    logic                 frame_done;
    logic                 abort;
`ifdef LB_SCHED_PERF_EN
    logic [23:0]          wr_stall_cnt;
    logic [23:0]          rd_wait_cnt;
`endif

    lb_window_sched_if bus ();

    lb_window_sched dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_frame_end   (frame_end),
        .r_hsize       (hsize),
        .r_vsize       (vsize),
        .bus           (bus.slave),
        .o_state       (state),
        .o_frame_done  (frame_done),
`ifdef LB_SCHED_PERF_EN
        .o_wr_stall_cnt(wr_stall_cnt),
        .o_rd_wait_cnt (rd_wait_cnt),
`endif
        .o_abort       (abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int      total = 0;
    int      bad   = 0;
    wr_exp_t wq[$];
    int      rq[$];
    logic    last_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample the write handshake on the falling edge, then look
    // for a grant just after the rising edge. The requester drops its request
    // as soon as it sees the grant.
    task automatic tick();
        wr_exp_t we;
        int      rb;
        @(negedge clk);
        last_ready = bus.o_wr_ready;
        if (bus.i_wr_valid && bus.o_wr_ready) begin
            if (wq.size() == 0) begin
                check("wr_unexpected_accept", 32'(wq.size()), 32'd1);
            end else begin
                we = wq.pop_front();
                check("wr_bank", 32'(bus.o_wr_bank), 32'(we.bank));
                check("wr_addr", 32'(bus.o_wr_addr), 32'(we.addr));
                $display("wr  bank=%0d addr=%0d", bus.o_wr_bank, bus.o_wr_addr);
            end
        end
        @(posedge clk);
        #1;
        if (bus.o_rd_gnt) begin
            if (rq.size() == 0) begin
                check("rd_unexpected_gnt", 32'(rq.size()), 32'd1);
            end else begin
                rb = rq.pop_front();
                check("rd_bank", 32'(bus.o_rd_bank), 32'(rb));
                $display("rd  gnt bank=%0d", bus.o_rd_bank);
            end
            bus.i_rd_req = 1'b0;
        end
    endtask

    initial begin
        wr_exp_t e;
        rst_n            = 1'b0;
        frame_start      = 1'b0;
        frame_end        = 1'b0;
        hsize            = 12'd4;
        vsize            = 11'd16;
        bus.i_wr_valid   = 1'b0;
        bus.i_rd_req     = 1'b0;
        bus.i_rd_row     = '0;
        bus.i_rd_release = 1'b0;
        last_ready       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_wr_ready", 32'(bus.o_wr_ready), 32'd0);
        check("rst_gnt", 32'(bus.o_rd_gnt), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_wr_bank", 32'(bus.o_wr_bank), 32'd0);
        check("rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
        check("rst_rd_bank", 32'(bus.o_rd_bank), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---- A: hsize=4 vsize=16, fill / run / drain ----
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("a_state_fill", 32'(state), 32'(LB_FILL));
        check("a_no_abort", 32'(abort), 32'd0);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 4; x++) begin
                e.bank = y; e.addr = x; wq.push_back(e);
            end
        bus.i_wr_valid = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            tick();
            check("a_wr_ready", 32'(last_ready), 32'd1);
            check("a_state", 32'(state), (n <= 32) ? 32'(LB_FILL) : 32'(LB_RUN));
            check("a_gnt_timing", 32'(bus.o_rd_gnt), (n == 34 || n == 45) ? 32'd1 : 32'd0);
            if (n == 5) begin
                bus.i_rd_req = 1'b1; bus.i_rd_row = 11'd3; rq.push_back(3);
            end
            if (n == 40) begin
                bus.i_rd_req = 1'b1; bus.i_rd_row = 11'd10; rq.push_back(10);
            end
        end
        bus.i_wr_valid = 1'b0;
        tick();
        check("a_state_drain", 32'(state), 32'(LB_DRAIN));
        for (int i = 0; i < 16; i++) begin
            bus.i_rd_release = 1'b1;
            tick();
            check("a_drain_hold", 32'(state), 32'(LB_DRAIN));
            check("a_drain_no_done", 32'(frame_done), 32'd0);
            check("a_drain_no_ready", 32'(last_ready), 32'd0);
        end
        bus.i_rd_release = 1'b0;
        tick();
        check("a_state_idle", 32'(state), 32'(LB_IDLE));
        check("a_done_pulse", 32'(frame_done), 32'd1);
        tick();
        check("a_done_single", 32'(frame_done), 32'd0);

        // ---- B: vsize=100, window backpressure ----
        vsize = 11'd100;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("b_state_fill", 32'(state), 32'(LB_FILL));
        check("b_no_abort_from_idle", 32'(abort), 32'd0);
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 4; x++) begin
                e.bank = y; e.addr = x; wq.push_back(e);
            end
        for (int x = 0; x < 4; x++) begin
            e.bank = 0; e.addr = x; wq.push_back(e);
        end
        bus.i_wr_valid = 1'b1;
        for (int n = 0; n < 256; n++) begin
            tick();
            check("b_wr_ready", 32'(last_ready), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_full_ready", 32'(last_ready), 32'd0);
            check("b_full_addr", 32'(bus.o_wr_addr), 32'd0);
            check("b_full_bank", 32'(bus.o_wr_bank), 32'd0);
        end
        bus.i_rd_release = 1'b1;
        tick();
        check("b_release_cycle_ready", 32'(last_ready), 32'd0);
        bus.i_rd_release = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b_ready_after_release", 32'(last_ready), 32'd1);
        end
        bus.i_wr_valid = 1'b0;
        check("b_state_run", 32'(state), 32'(LB_RUN));
        // row 0 is below low_row=1: never granted
        bus.i_rd_req = 1'b1;
        bus.i_rd_row = 11'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_below_low_no_gnt", 32'(bus.o_rd_gnt), 32'd0);
        end
        bus.i_rd_req = 1'b0;
        tick();
        // row 64 lives in bank 0
        bus.i_rd_req = 1'b1;
        bus.i_rd_row = 11'd64;
        rq.push_back(0);
        tick();
        check("b_gnt_row64", 32'(bus.o_rd_gnt), 32'd1);
        tick();
        check("b_gnt_one_cycle", 32'(bus.o_rd_gnt), 32'd0);

        // ---- C: abort mid-RUN drops a grantable pending request ----
        bus.i_rd_req = 1'b1;
        bus.i_rd_row = 11'd5;
        frame_start  = 1'b1;
        tick();
        frame_start  = 1'b0;
        check("c_abort_pulse", 32'(abort), 32'd1);
        check("c_state_fill", 32'(state), 32'(LB_FILL));
        check("c_gnt_dropped", 32'(bus.o_rd_gnt), 32'd0);
        check("c_wr_addr_clr", 32'(bus.o_wr_addr), 32'd0);
        check("c_wr_bank_clr", 32'(bus.o_wr_bank), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("c_no_gnt", 32'(bus.o_rd_gnt), 32'd0);
            check("c_abort_single", 32'(abort), 32'd0);
            check("c_state_hold", 32'(state), 32'(LB_FILL));
        end
        bus.i_rd_req = 1'b0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("c_end_idle", 32'(state), 32'(LB_IDLE));
        check("c_end_done", 32'(frame_done), 32'd1);
        tick();
        check("c_done_single", 32'(frame_done), 32'd0);

        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
